// File: rtl/pin_teclado_pkg.sv
// Shared definitions for the keypad PIN entry stage and the gate controller.
package pin_teclado_pkg;

   localparam logic [3:0] TECLA_BORRAR = 4'hA;
   localparam logic [3:0] TECLA_ENVIAR = 4'hB;
   localparam logic [7:0] PIN_ESPERA   = 8'h00;

   typedef enum logic [2:0] {
      ESPERA = 3'b001,
      UNO    = 3'b010,
      DOS    = 3'b100
   } estado_t;

   function automatic logic es_digito(input logic [3:0] tecla);
      return tecla <= 4'd9;
   endfunction

endpackage

// File: rtl/pin_teclado_detector_flanco.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
module detector_flanco (
   input  logic Clk,
   input  logic Reset,
   input  logic Senal,
   output logic Flanco
);

   logic senal_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         senal_q <= 1'b0;
      end else begin
         senal_q <= Senal;
      end
   end

   assign Flanco = Senal & ~senal_q;

endmodule

// File: rtl/pin_teclado.sv
// Keypad entry stage: gathers two BCD digits and presents them as a one-cycle PIN attempt.
module pin_teclado
   import pin_teclado_pkg::*;
#(
   parameter int unsigned TIMEOUT_CICLOS = 1000,
   parameter int unsigned CW             = 10
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Vehiculo,
   input  logic       Tecla_valida,
   input  logic [3:0] Tecla,
   output logic [7:0] Pin,
   output logic       Error,
   output logic [1:0] Digitos
);

   estado_t       estado;
   logic [3:0]    digito_alto;
   logic [3:0]    digito_bajo;
   logic [CW-1:0] cuenta;
   logic          evento;

   detector_flanco u_detector_flanco (
      .Clk    (Clk),
      .Reset  (Reset),
      .Senal  (Tecla_valida),
      .Flanco (evento)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         estado      <= ESPERA;
         digito_alto <= 4'd0;
         digito_bajo <= 4'd0;
         cuenta      <= '0;
         Pin         <= PIN_ESPERA;
         Error       <= 1'b0;
         Digitos     <= 2'd0;
      end else begin
         Pin   <= PIN_ESPERA;
         Error <= 1'b0;
         if (!Vehiculo) begin
            // ESPERA already holds a cleared entry, so clearing unconditionally is safe
            estado      <= ESPERA;
            digito_alto <= 4'd0;
            digito_bajo <= 4'd0;
            cuenta      <= '0;
            Digitos     <= 2'd0;
         end else if (evento) begin
            cuenta <= '0;
            if (es_digito(Tecla)) begin
               case (estado)
                  ESPERA: begin
                     digito_alto <= Tecla;
                     estado      <= UNO;
                     Digitos     <= 2'd1;
                  end
                  UNO: begin
                     digito_bajo <= Tecla;
                     estado      <= DOS;
                     Digitos     <= 2'd2;
                  end
                  default: ;
               endcase
            end else if (Tecla == TECLA_BORRAR || Tecla == TECLA_ENVIAR) begin
               if (Tecla == TECLA_ENVIAR) begin
                  if (estado == DOS && {digito_alto, digito_bajo} != PIN_ESPERA) begin
                     Pin <= {digito_alto, digito_bajo};
                  end else begin
                     Error <= 1'b1;
                  end
               end
               estado      <= ESPERA;
               digito_alto <= 4'd0;
               digito_bajo <= 4'd0;
               Digitos     <= 2'd0;
            end
         end else if (estado != ESPERA) begin
            if (cuenta == CW'(TIMEOUT_CICLOS - 1)) begin
               Error       <= 1'b1;
               estado      <= ESPERA;
               digito_alto <= 4'd0;
               digito_bajo <= 4'd0;
               cuenta      <= '0;
               Digitos     <= 2'd0;
            end else begin
               cuenta <= cuenta + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pin_teclado.sv
// Directed bench for pin_teclado with hand-computed expected values.
module tb_pin_teclado;

   localparam int unsigned TIMEOUT = 1000;

   logic       Clk;
   logic       Reset;
   logic       Vehiculo;
   logic       Tecla_valida;
   logic [3:0] Tecla;
   logic [7:0] Pin;
   logic       Error;
   logic [1:0] Digitos;

   int n_tests;
   int n_fail;

   logic [7:0] pin_pulso;
   logic       err_pulso;
   logic [7:0] pin_despues;
   logic       err_despues;

   pin_teclado #(
      .TIMEOUT_CICLOS (TIMEOUT),
      .CW             (10)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Vehiculo     (Vehiculo),
      .Tecla_valida (Tecla_valida),
      .Tecla        (Tecla),
      .Pin          (Pin),
      .Error        (Error),
      .Digitos      (Digitos)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_tests++;
      if (obs !== esp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // One-cycle key press; records outputs right after the event edge and one cycle later.
   task automatic press(input logic [3:0] k);
      Tecla        = k;
      Tecla_valida = 1'b1;
      tick();
      pin_pulso    = Pin;
      err_pulso    = Error;
      Tecla_valida = 1'b0;
      tick();
      pin_despues  = Pin;
      err_despues  = Error;
   endtask

   initial begin
      int err_temprano;
      int pulsos;
      n_tests      = 0;
      n_fail       = 0;
      Reset        = 1'b0;
      Vehiculo     = 1'b0;
      Tecla_valida = 1'b0;
      Tecla        = 4'h0;
      tick();
      check("reset_pin", 32'(Pin), 32'h00);
      check("reset_error", 32'(Error), 32'h0);
      check("reset_digitos", 32'(Digitos), 32'h0);
      Reset = 1'b1;
      Vehiculo = 1'b1;
      tick();

      // 0, 8, enviar -> 8'h08
      press(4'h0);
      check("s1_digitos1", 32'(Digitos), 32'd1);
      press(4'h8);
      check("s1_digitos2", 32'(Digitos), 32'd2);
      press(4'hB);
      check("s1_pin_pulso", 32'(pin_pulso), 32'h08);
      check("s1_err_pulso", 32'(err_pulso), 32'h0);
      check("s1_pin_despues", 32'(pin_despues), 32'h00);
      check("s1_digitos0", 32'(Digitos), 32'd0);

      // 3, enviar -> error
      press(4'h3);
      press(4'hB);
      check("s2_err_pulso", 32'(err_pulso), 32'h1);
      check("s2_pin", 32'(pin_pulso), 32'h00);
      check("s2_err_despues", 32'(err_despues), 32'h0);
      check("s2_digitos", 32'(Digitos), 32'd0);

      // 0, 0, enviar -> error, pin stays zero
      press(4'h0);
      press(4'h0);
      press(4'hB);
      check("s3_err_pulso", 32'(err_pulso), 32'h1);
      check("s3_pin", 32'(pin_pulso), 32'h00);

      // 5, then idle: error exactly TIMEOUT edges after the key edge
      press(4'h5);
      err_temprano = 0;
      for (int i = 0; i < int'(TIMEOUT) - 2; i++) begin
         tick();
         if (Error) err_temprano++;
      end
      check("s4_sin_error_previo", 32'(err_temprano), 32'd0);
      check("s4_digitos_antes", 32'(Digitos), 32'd1);
      tick();
      check("s4_timeout_error", 32'(Error), 32'h1);
      check("s4_digitos", 32'(Digitos), 32'd0);
      tick();
      check("s4_error_un_ciclo", 32'(Error), 32'h0);
      press(4'h1);
      press(4'h2);
      press(4'hB);
      check("s4_pin_12", 32'(pin_pulso), 32'h12);

      // 4, 7, 9 (ignored), borrar, 2, 1, held enviar -> 8'h21 once
      press(4'h4);
      press(4'h7);
      press(4'h9);
      check("s5_digitos_llenos", 32'(Digitos), 32'd2);
      check("s5_sin_error_tercero", 32'(err_pulso), 32'h0);
      press(4'hA);
      check("s5_borrar_digitos", 32'(Digitos), 32'd0);
      check("s5_borrar_sin_error", 32'(err_pulso), 32'h0);
      press(4'hE);
      check("s5_codigo_ignorado", 32'(Digitos), 32'd0);
      press(4'h2);
      press(4'h1);
      Tecla        = 4'hB;
      Tecla_valida = 1'b1;
      tick();
      check("s5_pin_21", 32'(Pin), 32'h21);
      pulsos = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (Pin != 8'h00) pulsos++;
      end
      Tecla_valida = 1'b0;
      tick();
      if (Pin != 8'h00) pulsos++;
      check("s5_un_solo_pulso", 32'(pulsos), 32'd1);

      // 6, 6, vehicle leaves -> cleared without error
      press(4'h6);
      press(4'h6);
      check("s6_digitos2", 32'(Digitos), 32'd2);
      Vehiculo = 1'b0;
      tick();
      check("s6_vehiculo_digitos", 32'(Digitos), 32'd0);
      check("s6_vehiculo_sin_error", 32'(Error), 32'h0);
      press(4'h6);
      check("s6_ignorado_digitos", 32'(Digitos), 32'd0);
      press(4'hB);
      check("s6_ignorado_enviar", 32'(err_pulso), 32'h0);

      // Reset asserted mid-cycle while a Pin pulse is on the bus
      Vehiculo = 1'b1;
      press(4'h6);
      press(4'h7);
      Tecla        = 4'hB;
      Tecla_valida = 1'b1;
      tick();
      check("s6_pin_67", 32'(Pin), 32'h67);
      #2;
      Reset = 1'b0;
      #1;
      check("s6_reset_pin", 32'(Pin), 32'h00);
      check("s6_reset_digitos", 32'(Digitos), 32'd0);
      Tecla_valida = 1'b0;
      tick();
      Reset = 1'b1;
      tick();
      press(4'h9);
      check("s6_post_reset_digito", 32'(Digitos), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
